// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//   This is the decoupled instruction-fetch front end. A request/acknowledge
//   fetch engine fills a DEPTH-entry circular FIFO of {instruction, pc} pairs,
//   and decode drains that FIFO through a valid/ready handshake. A flush
//   redirects fetch to flush_pc and discards everything that is queued.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active-low (0 = in reset)
//   imem_req    fetch request, registered, held until acknowledged
//   imem_addr   fetch address, registered, stable while imem_req=1
//   imem_ack    memory accepts the request and returns imem_rdata this cycle
//   imem_rdata  instruction word, valid with imem_ack
//   flush       redirect: drop queue contents, refetch from flush_pc
//   flush_pc    redirect target
//   out_valid   head entry valid (count != 0)
//   out_ready   consumer accepts the head entry
//   out_instr   head instruction (0 when empty)
//   out_pc      address of the head instruction (0 when empty)
//   count       number of occupied entries
// -----------------------------------------------------------------------------
module prefetch_queue #(
   parameter int unsigned       bus      = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [bus-1:0]    RESET_PC = '0,
   parameter int unsigned       STEP     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [bus-1:0]             imem_addr,
   input  logic                       imem_ack,
   input  logic [bus-1:0]             imem_rdata,
   input  logic                       flush,
   input  logic [bus-1:0]             flush_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [bus-1:0]             out_instr,
   output logic [bus-1:0]             out_pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   // IDLE: no request. REQ: live request at fetch_pc.
   // DROP: request abandoned by a flush, still waiting for its ack.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state_q,    state_d;
   logic [bus-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [CW-1:0]   count_q,    count_d;
   logic            req_q,      req_d;
   logic [bus-1:0]  addr_q,     addr_d;

   logic [bus-1:0]  instr_mem [DEPTH];
   logic [bus-1:0]  pc_mem    [DEPTH];

   logic            push;
   logic            pop;
   logic [CW-1:0]   count_after;
   logic            space;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      req_d      = req_q;
      addr_d     = addr_q;

      pop         = (count_q != '0) && out_ready && !flush;
      push        = (state_q == REQ) && imem_ack && !flush;
      count_after = count_q + CW'(push) - CW'(pop);
      // Issue a new request only when its data is guaranteed a free slot.
      space       = (count_after < CW'(DEPTH));

      if (flush) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = flush_pc;
         req_d      = 1'b1;
         if ((state_q != IDLE) && !imem_ack) begin
            // The memory still owes an ack for the old address. Keep the
            // request up at that address and discard its data when it arrives.
            state_d = DROP;
         end else begin
            // Either nothing is outstanding or the outstanding request
            // finishes in this cycle. In both cases fetch can go straight to
            // the redirect target.
            state_d = REQ;
            addr_d  = flush_pc;
         end
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_after;

         unique case (state_q)
            IDLE: begin
               if (space) begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  addr_d  = fetch_pc_q;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  fetch_pc_d = fetch_pc_q + bus'(STEP);
                  if (space) begin
                     addr_d = fetch_pc_d;
                  end else begin
                     state_d = IDLE;
                     req_d   = 1'b0;
                  end
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every flop
   // samples its _d value from the same edge, so evaluation order cannot
   // change the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

   // NOTE: the entry storage is not reset. Its contents are only observed
   // through count_q, which is reset, so reset logic on the array would buy
   // nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q]    <= addr_q;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign count     = count_q;
   assign out_valid = (count_q != '0);
   assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;

endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
//   This is the self-checking bench for prefetch_queue. The reference model
//   tracks a queue of {instr, pc} entries and one pending memory request that
//   is either live or being dropped. After every clock edge the bench compares
//   the DUT outputs with that model. Directed scenarios come first, followed
//   by a randomized phase.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;

   localparam int unsigned BUS      = 32;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned STEP     = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam int unsigned CW       = $clog2(DEPTH) + 1;

   logic           clk;
   logic           reset;
   logic           imem_req;
   logic [31:0]    imem_addr;
   logic           imem_ack;
   logic [31:0]    imem_rdata;
   logic           flush;
   logic [31:0]    flush_pc;
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_instr;
   logic [31:0]    out_pc;
   logic [CW-1:0]  count;

   prefetch_queue #(
      .bus      (BUS),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .STEP     (STEP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .flush      (flush),
      .flush_pc   (flush_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   bit          m_req;      // a request is on the bus
   bit          m_drop;     // that request was abandoned by a flush
   logic [31:0] m_addr;
   logic [31:0] m_fetch_pc;

   task automatic model_reset();
      q.delete();
      m_req      = 1'b0;
      m_drop     = 1'b0;
      m_addr     = RESET_PC;
      m_fetch_pc = RESET_PC;
   endtask

   task automatic model_update(input bit ack, input bit fl, input logic [31:0] fpc,
                               input bit rdy, input logic [31:0] rdata);
      bit pop;
      bit push;
      pop  = (q.size() != 0) && rdy && !fl;
      push = m_req && !m_drop && ack && !fl;
      if (fl) begin
         q.delete();
         m_fetch_pc = fpc;
         if (m_req && !ack) begin
            m_drop = 1'b1;
         end else begin
            m_drop = 1'b0;
            m_addr = fpc;
         end
         m_req = 1'b1;
      end else begin
         if (push) begin
            q.push_back('{instr: rdata, pc: m_addr});
            m_fetch_pc = m_fetch_pc + STEP;
         end
         if (pop) begin
            void'(q.pop_front());
         end
         if (m_drop) begin
            if (ack) begin
               m_drop = 1'b0;
               m_req  = 1'b0;
            end
         end else if (!m_req || ack) begin
            if (q.size() < DEPTH) begin
               m_req  = 1'b1;
               m_addr = m_fetch_pc;
            end else begin
               m_req = 1'b0;
            end
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      e_instr = (q.size() != 0) ? q[0].instr : 32'h0;
      e_pc    = (q.size() != 0) ? q[0].pc    : 32'h0;
      check({tag, ".req"},   32'(imem_req),  32'(m_req));
      if (m_req) check({tag, ".addr"}, imem_addr, m_addr);
      check({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
      check({tag, ".instr"}, out_instr, e_instr);
      check({tag, ".pc"},    out_pc, e_pc);
      check({tag, ".count"}, 32'(count), 32'(q.size()));
   endtask

   // One clock cycle: drive inputs, clock, advance the model, compare.
   // The bench memory only acks while a request is up.
   task automatic step(input bit ack, input bit fl, input logic [31:0] fpc,
                       input bit rdy, input string tag);
      logic [31:0] rd;
      rd         = $urandom();
      ack        = ack && m_req;
      imem_ack   = ack;
      imem_rdata = rd;
      flush      = fl;
      flush_pc   = fpc;
      out_ready  = rdy;
      @(posedge clk);
      model_update(ack, fl, fpc, rdy, rd);
      #1;
      check_all(tag);
   endtask

   // Assert reset away from a clock edge, check the outputs it clears
   // asynchronously, then release it just after the next edge.
   task automatic do_reset(input string tag);
      reset     = 1'b0;
      imem_ack  = 1'b0;
      flush     = 1'b0;
      flush_pc  = 32'h0;
      out_ready = 1'b0;
      #2;
      model_reset();
      check_all(tag);
      check({tag, ".rst_addr"}, imem_addr, RESET_PC);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      imem_rdata = 32'h0;
      model_reset();
      do_reset("rst0");

      // Streaming: memory acks every cycle, consumer always ready.
      step(1'b0, 1'b0, 32'h0, 1'b1, "t1.first");
      check("t1.first_addr", imem_addr, 32'h0);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1, "t1.ack");
         check("t1.next_addr", imem_addr, 32'(STEP * (k + 1)));
         check("t1.head_pc",   out_pc,    32'(STEP * k));
         check("t1.valid",     32'(out_valid), 32'd1);
      end

      // Back-pressure: fill the FIFO, then free one slot.
      do_reset("rst1");
      step(1'b0, 1'b0, 32'h0, 1'b0, "t2.first");
      for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'h0, 1'b0, "t2.fill");
      check("t2.full_count", 32'(count), 32'(DEPTH));
      check("t2.full_req",   32'(imem_req), 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, "t2.pop");
      check("t2.pop_count", 32'(count), 32'(DEPTH - 1));
      check("t2.pop_req",   32'(imem_req), 32'd1);
      check("t2.pop_addr",  imem_addr, 32'h10);

      // Slow memory: the address must hold over three wait cycles.
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, "t3.wait");
         check("t3.hold_addr", imem_addr, 32'h10);
         check("t3.hold_req",  32'(imem_req), 32'd1);
      end
      step(1'b1, 1'b0, 32'h0, 1'b0, "t3.ack");
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1, "t3.drain");

      // Flush while the request to 0x8 is still waiting for its ack.
      do_reset("rst2");
      step(1'b0, 1'b0, 32'h0, 1'b0, "t4.first");
      step(1'b1, 1'b0, 32'h0, 1'b0, "t4.ack0");
      step(1'b1, 1'b0, 32'h0, 1'b0, "t4.ack4");
      check("t4.pending", imem_addr, 32'h8);
      step(1'b0, 1'b1, 32'h100, 1'b0, "t4.flush");
      check("t4.drop_addr",  imem_addr, 32'h8);
      check("t4.drop_count", 32'(count), 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, "t4.drop_wait");
      step(1'b1, 1'b0, 32'h0, 1'b1, "t4.drop_ack");
      check("t4.discard_valid", 32'(out_valid), 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b0, "t4.restart");
      check("t4.redirect_addr", imem_addr, 32'h100);
      step(1'b1, 1'b0, 32'h0, 1'b0, "t4.fill");
      check("t4.head_pc", out_pc, 32'h100);

      // Flush together with an ack and a pop.
      step(1'b1, 1'b1, 32'h200, 1'b1, "t5.flush_ack");
      check("t5.count", 32'(count), 32'd0);
      check("t5.addr",  imem_addr, 32'h200);

      // Reset arrives mid-stream with two entries queued.
      step(1'b1, 1'b0, 32'h0, 1'b0, "t6.a");
      step(1'b1, 1'b0, 32'h0, 1'b0, "t6.b");
      check("t6.count2", 32'(count), 32'd2);
      do_reset("t6.rst");
      check("t6.rst_valid", 32'(out_valid), 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, "t6.restart");
      check("t6.restart_addr", imem_addr, RESET_PC);

      // Consecutive flushes during DROP: the last target wins.
      step(1'b0, 1'b1, 32'h300, 1'b1, "t7.flush_a");
      step(1'b0, 1'b1, 32'h400, 1'b1, "t7.flush_b");
      step(1'b1, 1'b0, 32'h0,   1'b1, "t7.ack");
      step(1'b0, 1'b0, 32'h0,   1'b1, "t7.restart");
      check("t7.last_wins", imem_addr, 32'h400);

      // Fetch address wraps past 2^32.
      step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, "t8.flush");
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0, 1'b1, "t8.wrap");
      check("t8.wrapped", imem_addr, 32'h8);

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         step(($urandom_range(2) != 0), ($urandom_range(15) == 0),
              ($urandom() & 32'hFFFF_FFFC), $urandom_range(1), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Decoupled instruction-fetch front end for the ARMv4 core.
- Replaces the combinational pc_out/instruction path with a request/acknowledge fetch engine feeding a DEPTH-entry FIFO of {instruction, pc} pairs.
- Tolerates variable instruction-memory latency.
- Decode consumes entries through a valid/ready handshake. On a taken branch or PC write, the core issues flush with the redirect target.

Parameters:
- bus, 32, data/address width in bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 0, fetch address after reset.
- STEP, 4, address increment per fetched instruction.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous, active-low (0 = in reset).
- imem_req  out  1  fetch request; held until acknowledged.
- imem_addr  out  bus  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory accepts the request and returns data this cycle.
- imem_rdata  in  bus  instruction word; valid when imem_ack=1.
- flush  in  1  redirect; discard queue contents and fetch from flush_pc.
- flush_pc  in  bus  redirect target.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_instr  out  bus  head instruction.
- out_pc  out  bus  address of the head instruction.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO pointers, count, imem_req and the state register all cleared.
  - out_valid=0; out_instr=0; out_pc=0; imem_addr=RESET_PC.
- Storage: circular buffer of DEPTH {instr, pc} entries with read/write pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
- Head output: out_valid = (count != 0). out_instr/out_pc driven from the read pointer. Outputs read 0 when empty.
- Pop: out_valid & out_ready & ~flush advances the read pointer.
- Push: imem_ack in state REQ writes {imem_rdata, imem_addr} and advances the write pointer. Push and pop in the same cycle leave count unchanged.
- At most one request is outstanding. The request is gated so the FIFO never overflows: a new request issues only if the next-cycle count < DEPTH.
- FSM states:
  - IDLE: imem_req=0. Move to REQ when space is available.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - ack & ~flush: push; fetch_pc += STEP (wraps mod 2^bus). Stay in REQ if space remains after this cycle's push/pop, else go to IDLE.
    - ~ack & flush: go to DROP.
  - DROP: imem_req=1, imem_addr held at the abandoned address. On ack, discard data and go to IDLE.
- imem_req and imem_addr are registered.
- First request appears the first rising edge after reset deasserts.
- Latency: ack at cycle t gives out_valid=1 at t+1. Sustained throughput is 1 instruction/cycle when memory acks every cycle and out_ready=1.
- Flush (highest priority, any state):
  - Pointers and count cleared next cycle; fetch_pc <= flush_pc.
  - Any pop in the flush cycle is ignored.
  - In IDLE, or in REQ with simultaneous ack: the acked data is discarded and the FSM goes to REQ with imem_addr=flush_pc.
  - In REQ without ack: go to DROP.
  - In DROP: stay in DROP; fetch_pc updated to the newer flush_pc (last flush wins).
- Full: count==DEPTH keeps imem_req=0 until a pop frees a slot. The request then issues the cycle after the pop.
- Empty with out_ready=1: no pop; the read pointer is unchanged.
- Reset mid-transfer: the outstanding request is abandoned immediately. Memory must tolerate imem_req dropping without ack.

Test Plan:
- Reset release, memory acks every cycle, out_ready=1: imem_addr 0,4,8,12 on consecutive cycles. out_pc 0,4,8 appear one cycle after each ack, with out_instr matching imem_rdata.
- out_ready=0, DEPTH=4: exactly 4 acks accepted, then count=4 and imem_req=0. One pop drops count to 3, and the next request (addr 16) issues the following cycle.
- Memory ack latency 3 cycles: imem_addr held stable while imem_req=1 for all 3 wait cycles. No second request while one is outstanding.
- flush (flush_pc=0x100) while a request to 0x8 is pending:
  - FSM enters DROP; the 0x8 data is discarded on ack.
  - Next request is to 0x100; count=0 and out_valid=0 until that data arrives.
- flush with simultaneous imem_ack and out_ready: FIFO empties, acked word dropped, no pop recorded. Next cycle imem_addr=flush_pc.
- Reset asserted mid-stream with count=2: outputs clear asynchronously. After release, fetch restarts at RESET_PC.
